// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parametrised single-clock FIFO.
// Pointers carry one extra wrap bit, so full and empty can be told apart
// without a separate counter. Every flag comes from the registered pointers
// only. Simultaneous read and write are both accepted, including a write
// into a full FIFO when a read is accepted in the same cycle. Read side
// is either first-word-fall-through (FWFT=1) or registered with one cycle
// of latency (FWFT=0).
//
// Handshake: a write is taken on a rising edge when wr_en is high and the
// FIFO is not full, or when it is full but a read is taken on the same
// edge. A read is taken when rd_en is high and the FIFO is not empty.
// There is no backpressure beyond the full/empty flags. A rejected request
// sets the matching sticky error flag. clr overrides both requests.
module sync_fifo_param #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 3,
    parameter int AFULL_TH  = 6,
    parameter int AEMPTY_TH = 2,
    parameter int FWFT      = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow
);

    localparam int              DEPTH        = 1 << ADDR_W;
    localparam logic [ADDR_W:0] C_PTR_ONE    = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0] C_AFULL_TH   = AFULL_TH[ADDR_W:0];
    localparam logic [ADDR_W:0] C_AEMPTY_TH  = AEMPTY_TH[ADDR_W:0];

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [ADDR_W:0]   r_wr_ptr;
    logic [ADDR_W:0]   r_rd_ptr;
    logic              r_overflow;
    logic              r_underflow;

    logic [ADDR_W:0]   w_count;
    logic              w_empty;
    logic              w_full;
    logic              w_rd_acc;
    logic              w_wr_acc;

    // Occupancy, flags and accept decisions from registered pointers and requests
    always_comb begin
        w_count  = r_wr_ptr - r_rd_ptr;
        w_empty  = (r_wr_ptr == r_rd_ptr);
        w_full   = (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]) &&
                   (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]);
        w_rd_acc = rd_en & ~w_empty & ~clr;
        w_wr_acc = wr_en & (~w_full | w_rd_acc) & ~clr;
    end

    assign count        = w_count;
    assign empty        = w_empty;
    assign full         = w_full;
    assign almost_full  = (w_count >= C_AFULL_TH);
    assign almost_empty = (w_count <= C_AEMPTY_TH);
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

    // Storage array; contents are deliberately left unreset
    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr[ADDR_W-1:0]] <= wr_data;
        end
    end

    // Write and read pointers, advanced on accepted requests, zeroed by flush
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
            end
        end
    end

    // Sticky error flags: set on a rejected request, held until flush or reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (clr) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (wr_en & ~w_wr_acc) begin
                r_overflow <= 1'b1;
            end
            if (rd_en & ~w_rd_acc) begin
                r_underflow <= 1'b1;
            end
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is presented combinationally whenever data is present
            assign rd_data  = r_mem[r_rd_ptr[ADDR_W-1:0]];
            assign rd_valid = ~w_empty;
        end else begin : g_reg
            logic [DATA_W-1:0] r_rd_data;
            logic              r_rd_valid;

            // Capture the head word on an accepted read; valid for one cycle
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_rd_data  <= '0;
                    r_rd_valid <= 1'b0;
                end else if (clr) begin
                    r_rd_valid <= 1'b0;
                end else begin
                    r_rd_valid <= w_rd_acc;
                    if (w_rd_acc) begin
                        r_rd_data <= r_mem[r_rd_ptr[ADDR_W-1:0]];
                    end
                end
            end

            assign rd_data  = r_rd_data;
            assign rd_valid = r_rd_valid;
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: one FWFT instance and one registered-read
// instance share the same stimulus and are checked against a queue model.
module tb_sync_fifo_param;

  localparam int DATA_W    = 16;
  localparam int ADDR_W    = 3;
  localparam int DEPTH     = 1 << ADDR_W;
  localparam int AFULL_TH  = 6;
  localparam int AEMPTY_TH = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              clr = 1'b0;
  logic              wr_en = 1'b0;
  logic [DATA_W-1:0] wr_data = '0;
  logic              rd_en = 1'b0;

  logic [DATA_W-1:0] f_rd_data, r_rd_data;
  logic              f_rd_valid, r_rd_valid;
  logic              f_full, r_full, f_empty, r_empty;
  logic              f_afull, r_afull, f_aempty, r_aempty;
  logic [ADDR_W:0]   f_count, r_count;
  logic              f_ovf, r_ovf, f_unf, r_unf;

  sync_fifo_param #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .AFULL_TH(AFULL_TH),
                    .AEMPTY_TH(AEMPTY_TH), .FWFT(1)) u_dut_f (
    .clk(clk), .rst_n(rst_n), .clr(clr), .wr_en(wr_en), .wr_data(wr_data),
    .rd_en(rd_en), .rd_data(f_rd_data), .rd_valid(f_rd_valid), .full(f_full),
    .empty(f_empty), .almost_full(f_afull), .almost_empty(f_aempty),
    .count(f_count), .overflow(f_ovf), .underflow(f_unf)
  );

  sync_fifo_param #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .AFULL_TH(AFULL_TH),
                    .AEMPTY_TH(AEMPTY_TH), .FWFT(0)) u_dut_r (
    .clk(clk), .rst_n(rst_n), .clr(clr), .wr_en(wr_en), .wr_data(wr_data),
    .rd_en(rd_en), .rd_data(r_rd_data), .rd_valid(r_rd_valid), .full(r_full),
    .empty(r_empty), .almost_full(r_afull), .almost_empty(r_aempty),
    .count(r_count), .overflow(r_ovf), .underflow(r_unf)
  );

  // ---------------- scoreboard / model ----------------
  logic [DATA_W-1:0] exp_q[$];
  logic              m_ovf = 1'b0;
  logic              m_unf = 1'b0;
  logic              m_rdv_r = 1'b0;
  logic [DATA_W-1:0] m_rdd_r = '0;

  int n_total = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    m_rdv_r = 1'b0;
    m_rdd_r = '0;
  endtask

  // One rising edge of the FIFO rules, in terms of a word queue
  task automatic model_step(input logic w, input logic [DATA_W-1:0] d,
                            input logic r, input logic c);
    logic racc, wacc;
    if (c) begin
      exp_q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
      m_rdv_r = 1'b0;
    end else begin
      racc = r && (exp_q.size() > 0);
      wacc = w && ((exp_q.size() < DEPTH) || racc);
      m_rdv_r = racc;
      if (racc) m_rdd_r = exp_q.pop_front();
      if (wacc) exp_q.push_back(d);
      if (w && !wacc) m_ovf = 1'b1;
      if (r && !racc) m_unf = 1'b1;
    end
  endtask

  task automatic check_model();
    int sz;
    sz = exp_q.size();
    chk("count_f", 32'(f_count), 32'(sz));
    chk("count_r", 32'(r_count), 32'(sz));
    chk("empty_f", 32'(f_empty), 32'(sz == 0));
    chk("full_f", 32'(f_full), 32'(sz == DEPTH));
    chk("full_r", 32'(r_full), 32'(sz == DEPTH));
    chk("afull_f", 32'(f_afull), 32'(sz >= AFULL_TH));
    chk("aempty_f", 32'(f_aempty), 32'(sz <= AEMPTY_TH));
    chk("aempty_r", 32'(r_aempty), 32'(sz <= AEMPTY_TH));
    chk("ovf_f", 32'(f_ovf), 32'(m_ovf));
    chk("unf_r", 32'(r_unf), 32'(m_unf));
    chk("rdvalid_f", 32'(f_rd_valid), 32'(sz != 0));
    if (sz != 0) chk("rddata_f", 32'(f_rd_data), 32'(exp_q[0]));
    chk("rdvalid_r", 32'(r_rd_valid), 32'(m_rdv_r));
    chk("rddata_r", 32'(r_rd_data), 32'(m_rdd_r));
  endtask

  // ---------------- driver ----------------
  task automatic do_cycle(input logic w, input logic [DATA_W-1:0] d,
                          input logic r, input logic c);
    wr_en = w;
    wr_data = d;
    rd_en = r;
    clr = c;
    @(posedge clk);
    model_step(w, d, r, c);
    @(negedge clk);
    check_model();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic              wr;
    logic [DATA_W-1:0] data;
    logic              rd;
    logic              c;
    int                exp_count;
    logic              exp_full;
    logic              exp_empty;
    logic              exp_ovf;
    logic              exp_unf;
    logic [DATA_W-1:0] exp_rdd_r;
  } vec_t;

  vec_t vecs[19];

  initial begin
    // fill 0x0001..0x0008
    for (int i = 0; i < 8; i++)
      vecs[i] = '{1'b1, DATA_W'(i + 1), 1'b0, 1'b0, i + 1, (i == 7), 1'b0, 1'b0, 1'b0, 16'h0000};
    // rejected write into full FIFO
    vecs[8] = '{1'b1, 16'hDEAD, 1'b0, 1'b0, 8, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000};
    // drain in order
    for (int k = 0; k < 8; k++)
      vecs[9 + k] = '{1'b0, 16'h0000, 1'b1, 1'b0, 7 - k, 1'b0, (k == 7), 1'b1, 1'b0, DATA_W'(k + 1)};
    // rejected read from empty FIFO
    vecs[17] = '{1'b0, 16'h0000, 1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0008};
    // flush with both requests high: nothing accepted, flags cleared
    vecs[18] = '{1'b1, 16'h7777, 1'b1, 1'b1, 0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0008};
  end

  // ---------------- test sequence ----------------
  initial begin
    logic [DATA_W-1:0] d;
    logic w, r, c;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_count_async", 32'(f_count), 32'd0);
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    check_model();
    chk("rst_rddata_r", 32'(r_rd_data), 32'd0);

    // table: fill, overflow, drain, underflow, flush
    for (int i = 0; i < 19; i++) begin
      do_cycle(vecs[i].wr, vecs[i].data, vecs[i].rd, vecs[i].c);
      chk("tbl_count", 32'(f_count), 32'(vecs[i].exp_count));
      chk("tbl_full", 32'(f_full), 32'(vecs[i].exp_full));
      chk("tbl_empty", 32'(r_empty), 32'(vecs[i].exp_empty));
      chk("tbl_ovf", 32'(r_ovf), 32'(vecs[i].exp_ovf));
      chk("tbl_unf", 32'(f_unf), 32'(vecs[i].exp_unf));
      chk("tbl_rdd_r", 32'(r_rd_data), 32'(vecs[i].exp_rdd_r));
    end

    // simultaneous access on a full FIFO
    for (int i = 0; i < 8; i++) do_cycle(1'b1, DATA_W'(16'h0010 + i), 1'b0, 1'b0);
    do_cycle(1'b1, 16'hBEEF, 1'b1, 1'b0);
    chk("full_rw_count", 32'(f_count), 32'd8);
    chk("full_rw_ovf", 32'(f_ovf), 32'd0);
    chk("full_rw_head", 32'(r_rd_data), 32'h0010);
    for (int i = 0; i < 8; i++) do_cycle(1'b0, 16'h0000, 1'b1, 1'b0);
    chk("beef_last", 32'(r_rd_data), 32'hBEEF);
    // simultaneous access on an empty FIFO: write only
    do_cycle(1'b1, 16'h4242, 1'b1, 1'b0);
    chk("empty_rw_count", 32'(f_count), 32'd1);
    chk("empty_rw_unf", 32'(f_unf), 32'd1);
    chk("empty_rw_head", 32'(f_rd_data), 32'h4242);
    do_cycle(1'b0, 16'h0000, 1'b0, 1'b1);

    // wrap-around streaming with 3 words preloaded
    for (int i = 0; i < 3; i++) do_cycle(1'b1, DATA_W'(16'h0100 + i), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      do_cycle(1'b1, DATA_W'(16'h0200 + i), 1'b1, 1'b0);
      chk("wrap_count", 32'(r_count), 32'd3);
      chk("wrap_rdd_r", 32'(r_rd_data), (i < 3) ? 32'(16'h0100 + i) : 32'(16'h0200 + i - 3));
    end
    do_cycle(1'b0, 16'h0000, 1'b0, 1'b1);

    // registered read latency
    do_cycle(1'b1, 16'h00A5, 1'b0, 1'b0);
    chk("lat_pre_valid", 32'(r_rd_valid), 32'd0);
    do_cycle(1'b0, 16'h0000, 1'b1, 1'b0);
    chk("lat_valid", 32'(r_rd_valid), 32'd1);
    chk("lat_data", 32'(r_rd_data), 32'h00A5);
    do_cycle(1'b0, 16'h0000, 1'b0, 1'b0);
    chk("lat_valid_drop", 32'(r_rd_valid), 32'd0);
    chk("lat_data_hold", 32'(r_rd_data), 32'h00A5);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      w = ($urandom_range(0, 99) < 55);
      r = ($urandom_range(0, 99) < 50);
      c = ($urandom_range(0, 99) < 3);
      d = DATA_W'($urandom);
      do_cycle(w, d, r, c);
    end

    // asynchronous reset between clock edges with 5 words held
    do_cycle(1'b0, 16'h0000, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) do_cycle(1'b1, DATA_W'(16'h0300 + i), 1'b0, 1'b0);
    do_cycle(1'b1, 16'h0304, 1'b1, 1'b0);
    do_cycle(1'b1, 16'h0305, 1'b0, 1'b0);
    chk("pre_rst_count", 32'(f_count), 32'd5);
    wr_en = 1'b0;
    rd_en = 1'b0;
    clr = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_count", 32'(f_count), 32'd0);
    chk("arst_empty", 32'(f_empty), 32'd1);
    chk("arst_valid_f", 32'(f_rd_valid), 32'd0);
    chk("arst_valid_r", 32'(r_rd_valid), 32'd0);
    chk("arst_rdd_r", 32'(r_rd_data), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_model();
    do_cycle(1'b1, 16'h1234, 1'b0, 1'b0);
    chk("post_rst_head", 32'(f_rd_data), 32'h1234);
    do_cycle(1'b0, 16'h0000, 1'b1, 1'b0);
    chk("post_rst_rdd_r", 32'(r_rd_data), 32'h1234);

    // ---------------- report ----------------
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
